wide_add_sequencer: RTL and testbench

Multi-cycle wide-operand add/subtract controller. It time-shares one 32-bit carrySelectAdder instance across WORDS 32-bit slices, least-significant first, and chains the carry between slices through a register. Requests arrive on a valid/ready start channel; results leave on a valid/ready result channel. Sits between a requester (ALU/bignum front end) and the shared adder datapath.

---
 rtl/wide_add_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_wide_add_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : wide_add_sequencer (with local carrySelectAdder)
//  Description : Multi-cycle wide add/subtract controller. One 32-bit
//                carry-select adder is reused across WORDS slices, LSB first,
//                with the inter-slice carry held in a register. Requests use
//                a valid/ready start channel, results a valid/ready result
//                channel.
//  Revision    : 1.0 - initial release
// ============================================================================

// 32-bit carry-select adder: four 8-bit blocks, each pre-computing both
// carry-in cases and selecting with the rippled block carry.
module carrySelectAdder (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o,
  output logic        overflow_o
);

  logic [4:0] w_carry;

  assign w_carry[0] = cin_i;

  for (genvar k = 0; k < 4; k++) begin : g_blk
    logic [8:0] w_s0;
    logic [8:0] w_s1;

    assign w_s0 = {1'b0, a_i[k*8 +: 8]} + {1'b0, b_i[k*8 +: 8]};
    assign w_s1 = {1'b0, a_i[k*8 +: 8]} + {1'b0, b_i[k*8 +: 8]} + 9'd1;
    assign sum_o[k*8 +: 8] = w_carry[k] ? w_s1[7:0] : w_s0[7:0];
    assign w_carry[k+1]    = w_carry[k] ? w_s1[8]   : w_s0[8];
  end

  assign cout_o     = w_carry[4];
  // Signed overflow: operands agree in sign but the sum does not.
  assign overflow_o = (a_i[31] == b_i[31]) && (sum_o[31] != a_i[31]);

endmodule

module wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [32*WORDS-1:0]   op_a,
  input  logic [32*WORDS-1:0]   op_b,
  input  logic                  sub,
  input  logic                  cin,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [32*WORDS-1:0]   result,
  output logic                  cout,
  output logic                  overflow,
  output logic                  busy
);

  localparam int W    = 32 * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [IDXW-1:0]  idx_q,    idx_d;
  logic [W-1:0]     a_q,      a_d;
  logic [W-1:0]     b_q,      b_d;
  logic             sub_q,    sub_d;
  logic             carry_q,  carry_d;
  logic [W-1:0]     result_q, result_d;
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;

  logic [31:0]      w_a_slice;
  logic [31:0]      w_b_slice;
  logic [31:0]      w_add_b;
  logic [31:0]      w_sum;
  logic             w_add_cout;
  logic             w_add_ovf;
  logic             w_last;

  // Select the operand slices addressed by the current word index.
  always_comb begin
    w_a_slice = '0;
    w_b_slice = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (int'(idx_q) == w) begin
        w_a_slice = a_q[w*32 +: 32];
        w_b_slice = b_q[w*32 +: 32];
      end
    end
  end

  // Subtraction feeds the inverted B slice; the +1 comes from the initial carry.
  assign w_add_b = sub_q ? ~w_b_slice : w_b_slice;
  assign w_last  = (int'(idx_q) == WORDS - 1);

  carrySelectAdder u_adder (
    .a_i        (w_a_slice),
    .b_i        (w_add_b),
    .cin_i      (carry_q),
    .sum_o      (w_sum),
    .cout_o     (w_add_cout),
    .overflow_o (w_add_ovf)
  );

  // Next-state logic for the sequencer and its datapath registers.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    carry_d     = carry_q;
    result_d    = result_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    start_ready = 1'b0;

    case (state_q)
      IDLE: begin
        start_ready = rst_n;
        if (start_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          sub_d   = sub;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int w = 0; w < WORDS; w++) begin
          if (int'(idx_q) == w) begin
            result_d[w*32 +: 32] = w_sum;
          end
        end
        carry_d = w_add_cout;
        idx_d   = idx_q + IDXW'(1);
        if (w_last) begin
          cout_d  = w_add_cout;
          ovf_d   = w_add_ovf;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result_valid = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign result       = result_q;
  assign cout         = cout_q;
  assign overflow     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_wide_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wide_add_sequencer
//  Description : Self-checking bench for wide_add_sequencer (WORDS=4 and 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wide_add_sequencer;

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic         sub;
    logic         cin;
    logic [127:0] r;
    logic         c;
    logic         o;
  } vec_t;

  typedef struct {
    logic [127:0] r;
    logic         c;
    logic         o;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid, start_ready, sub, cin;
  logic         result_valid, result_ready, cout, overflow, busy;
  logic [127:0] op_a, op_b, result;

  logic         sv1, sr1, sub1, cin1, rv1, rr1, c1, o1, busy1;
  logic [31:0]  a1, b1, r1;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   rv_seen  = 1'b0;
  exp_t sb[$];
  vec_t tbl[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wide_add_sequencer #(.WORDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .cin(cin), .result_valid(result_valid),
    .result_ready(result_ready), .result(result), .cout(cout), .overflow(overflow),
    .busy(busy)
  );

  wide_add_sequencer #(.WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1),
    .op_a(a1), .op_b(b1), .sub(sub1), .cin(cin1), .result_valid(rv1),
    .result_ready(rr1), .result(r1), .cout(c1), .overflow(o1), .busy(busy1)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Independent reference: full-width arithmetic on 129 bits.
  function automatic vec_t model(input logic [127:0] a, input logic [127:0] b,
                                 input logic s, input logic ci);
    vec_t         v;
    logic [127:0] bb;
    logic [128:0] t;
    bb    = s ? ~b : b;
    t     = {1'b0, a} + {1'b0, bb} + 129'(s ? 1'b1 : ci);
    v.a   = a;   v.b = b;   v.sub = s;   v.cin = ci;
    v.r   = t[127:0];
    v.c   = t[128];
    v.o   = (a[127] == bb[127]) && (t[127] != a[127]);
    return v;
  endfunction

  // Scoreboard consumer: latency on rising valid, values on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && result_valid && !rv_seen) begin
      rv_seen = 1'b1;
      if (sb.size() == 0) chk("unexpected_valid", 1, 0);
      else chk("latency", 128'(cyc - sb[0].acc), 128'(4));
    end
    if (!result_valid) rv_seen = 1'b0;
    if (rst_n && result_valid && result_ready && sb.size() > 0) begin
      e = sb.pop_front();
      chk("result", result, e.r);
      chk("cout", cout, e.c);
      chk("overflow", overflow, e.o);
    end
  end

  task automatic issue(input vec_t v);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    op_a = v.a; op_b = v.b; sub = v.sub; cin = v.cin; start_valid = 1'b1;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (start_ready) begin
        got = 1'b1;
        sb.push_back('{v.r, v.c, v.o, cyc + 1});
      end
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      chk("drain_timeout", 128'(sb.size()), 0);
      sb.delete();
    end
  endtask

  task automatic w1(input logic [31:0] a, input logic [31:0] b, input logic s,
                    input logic ci, input logic [31:0] er, input logic ec, input logic eo);
    @(posedge clk); #1;
    a1 = a; b1 = b; sub1 = s; cin1 = ci; sv1 = 1'b1;
    @(negedge clk); chk("w1_ready", sr1, 1);
    @(posedge clk); #1; sv1 = 1'b0;
    @(negedge clk); chk("w1_valid_early", rv1, 0); chk("w1_busy", busy1, 1);
    @(negedge clk); chk("w1_valid", rv1, 1);
    chk("w1_result", r1, er); chk("w1_cout", c1, ec); chk("w1_ovf", o1, eo);
    @(negedge clk); chk("w1_valid_drop", rv1, 0); chk("w1_ready_again", sr1, 1);
  endtask

  initial begin
    vec_t x, y;
    tbl[0] = '{128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, 1'b0,
               128'h0000_0000_0000_0001_0000_0000_0000_0000, 1'b0, 1'b0};
    tbl[1] = '{{128{1'b1}}, 128'h0, 1'b0, 1'b1, 128'h0, 1'b1, 1'b0};
    tbl[2] = '{128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, 1'b0,
               128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1};
    tbl[3] = '{128'h8000_0000_0000_0000_0000_0000_0000_0000,
               128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0, 128'h0, 1'b1, 1'b1};
    tbl[4] = '{128'h0, 128'h1, 1'b1, 1'b1, {128{1'b1}}, 1'b0, 1'b0};
    tbl[5] = '{128'h1234_5678_9ABC_DEF0_0F0F_0F0F_F0F0_F0F0,
               128'h1234_5678_9ABC_DEF0_0F0F_0F0F_F0F0_F0F0, 1'b1, 1'b0, 128'h0, 1'b1, 1'b0};
    tbl[6] = '{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
               128'h1111_1111_1111_1111_1111_1111_1111_1111, 1'b0, 1'b1,
               128'h1234_5678_9ABC_DF01_0FED_CBA9_8765_4322, 1'b0, 1'b0};
    tbl[7] = '{128'h1_0000_0000, 128'h1, 1'b1, 1'b0, 128'hFFFF_FFFF, 1'b1, 1'b0};

    rst_n = 1'b0; start_valid = 1'b0; result_ready = 1'b1;
    op_a = '0; op_b = '0; sub = 1'b0; cin = 1'b0;
    sv1 = 1'b0; rr1 = 1'b1; a1 = '0; b1 = '0; sub1 = 1'b0; cin1 = 1'b0;

    // Reset state, including start_ready held low while reset is asserted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_start_ready", start_ready, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst1_start_ready", sr1, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("idle_start_ready", start_ready, 1);

    // Directed vectors, then model-checked random vectors.
    for (int i = 0; i < 8; i++) issue(tbl[i]);
    drain();
    for (int i = 0; i < 6; i++) begin
      x = model({$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom},
                1'($urandom_range(1)), 1'($urandom_range(1)));
      issue(x);
    end
    drain();

    // Backpressure: result held, new request refused until the handshake.
    result_ready = 1'b0;
    x = tbl[6];
    y = model(128'h5, 128'h3, 1'b1, 1'b0);
    issue(x);
    for (int i = 0; i < 20 && !result_valid; i++) @(negedge clk);
    chk("bp_valid", result_valid, 1);
    @(posedge clk); #1;
    op_a = y.a; op_b = y.b; sub = y.sub; cin = y.cin; start_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_start_ready", start_ready, 0);
      chk("bp_result_hold", result, x.r);
    end
    @(posedge clk); #1; result_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_valid_drop", result_valid, 0);
    chk("bp_ready_back", start_ready, 1);
    sb.push_back('{y.r, y.c, y.o, cyc + 1});
    @(posedge clk); #1; start_valid = 1'b0;
    drain();

    // Reset while the word index is 2: operation abandoned, no result.
    issue(tbl[6]);
    @(posedge clk); @(posedge clk); #1;
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", result_valid, 0);
    chk("mid_rst_ready", start_ready, 1);
    repeat (8) @(negedge clk);
    chk("mid_rst_still_idle", busy, 0);

    // Single-slice instance: one-cycle RUN.
    w1(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    w1(32'h5, 32'h7, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    w1(32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
